fetch_ctrl_multibuf: RTL and testbench
======================================

Name: fetch_ctrl_multibuf

Overview:
Parametrised successor to the weight/bias/input BRAM fetch controller. Streams a programmable-length tile of DATA_WIDTH words from one of NUM_BUFFERS regions of a shared read port onto a valid/ready stream toward the systolic array. Adds arbitrary tile length, automatic ping-pong bank toggling for double buffering, downstream backpressure via a credit-limited output FIFO, and configuration-error reporting. Sits between the buffer BRAM read port and the array feeder.

Parameters:
ADDR_WIDTH, 16, BRAM read-address width
DATA_WIDTH, 256, read word width
NUM_BUFFERS, 4, buffer regions on the read port
BUF_DEPTH, 1024, words per region (power of 2; NUM_BUFFERS*BUF_DEPTH <= 2**ADDR_WIDTH)
RD_LATENCY, 2, BRAM read latency in cycles (>=1)
FIFO_DEPTH, 4, output FIFO entries (>= RD_LATENCY+2 for full throughput)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_fetch  in  1  start request, sampled in IDLE
reset_addr_counter  in  1  clear offset counter and bank, sampled in IDLE
buf_sel  in  $clog2(NUM_BUFFERS)  region select
tile_len  in  $clog2(BUF_DEPTH)+1  words per fetch
double_buffering  in  1  use half-region ping-pong banks
bram_enb  out  1  read enable
bram_addrb  out  ADDR_WIDTH  read address
bram_doutb  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after bram_enb
out_data  out  DATA_WIDTH  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
fetch_done  out  1  one-cycle completion pulse
busy  out  1  high from accepted start until fetch_done
err_cfg  out  1  one-cycle pulse on rejected start
cur_bank  out  1  current ping-pong bank

Behaviour:
- Reset: all outputs 0, offset 0, bank 0, FIFO empty, state IDLE. Asynchronous; mid-fetch reset aborts, in-flight reads discarded.
- Region size R = double_buffering ? BUF_DEPTH/2 : BUF_DEPTH. Address = buf_sel*BUF_DEPTH + (double_buffering ? cur_bank*BUF_DEPTH/2 : 0) + offset.
- States: IDLE -> ISSUE (start accepted) -> DRAIN (all reads issued) -> DONE (last word handshaken) -> IDLE.
- IDLE: reset_addr_counter clears offset and cur_bank. If asserted with start_fetch in the same cycle, clear applies first; fetch begins at offset 0, bank 0.
- Start validity: tile_len == 0 or tile_len > R -> start ignored, err_cfg pulses next cycle, stay IDLE. Otherwise buf_sel, tile_len and double_buffering latch; busy rises next cycle.
- ISSUE: bram_enb asserted when outstanding + fifo_count < FIFO_DEPTH; each issue increments offset, wrapping modulo R. Issue count equals latched tile_len.
- Offset persists across fetches unless cleared, so consecutive fetches walk the region.
- Data capture: RD_LATENCY-deep valid shift register pushes bram_doutb into FIFO; credits guarantee no overflow.
- Output: out_valid = FIFO non-empty; pop on out_valid & out_ready; out_data stable while out_valid & !out_ready.
- Latency (out_ready=1, empty FIFO): first bram_enb 1 cycle after accepted start, first out_valid RD_LATENCY+1 cycles after first bram_enb, then 1 word/cycle.
- DONE: fetch_done pulses the cycle after the final handshake; busy falls the same cycle. If double_buffering was latched, cur_bank toggles and offset returns to 0 that cycle.
- start_fetch and reset_addr_counter ignored while busy.
- Inputs buf_sel/tile_len/double_buffering changing during busy have no effect.

Decomposition:
- Shared package fetch_pkg: FSM state encoding, localparams BUF_SEL_W, TILE_W, OFFS_W, region-size helper.
- One sub-module: sync_fifo_fwft (parametrised width/depth, count output) for the output buffer; address/credit/FSM logic stays in the top.

Test Plan:
- buf_sel=0, tile_len=32, db=0, out_ready=1, BRAM model word=address -> addresses 0..31, out_data 0..31, one word/cycle, fetch_done 1 cycle after word 31, busy low.
- Second fetch without reset_addr_counter, tile_len=32 -> addresses 32..63; then reset_addr_counter + fetch buf_sel=2, tile_len=512 -> addresses 2048..2559.
- db=1, buf_sel=0, tile_len=512, three fetches -> bases 0, 512, 0; cur_bank 0->1->0 after each fetch_done.
- Backpressure: tile_len=16, out_ready toggling 1-of-3 cycles -> all 16 words in order, no drop/duplicate, bram_enb stalls once FIFO_DEPTH credits are used.
- tile_len=0 and tile_len=600 with db=1 -> err_cfg pulse, busy stays 0, no bram_enb.
- rst_n low mid-fetch (after word 5 of 32) -> all outputs 0 immediately; fresh fetch of 8 words starts at address 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding, default geometry widths and region-size helper
// for the multi-buffer fetch controller.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    localparam int NUM_BUFFERS_DEF = 4;
    localparam int BUF_DEPTH_DEF = 1024;
    localparam int BUF_SEL_W = $clog2(NUM_BUFFERS_DEF);
    localparam int TILE_W = $clog2(BUF_DEPTH_DEF) + 1;
    localparam int OFFS_W = $clog2(BUF_DEPTH_DEF);
    // Words addressable per fetch: half the region when ping-ponging banks.
    function automatic int region_size(input int depth, input logic db);
        return db ? depth / 2 : depth;
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with occupancy count.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, data_i  : write strobe and data (ignored when full and not popping)
//   pop_i           : consume head entry (ignored when empty)
//   data_o, valid_o : head entry (forced to 0 when empty) and non-empty flag
//   count_o         : number of stored entries
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;
    assign do_pop = pop_i && cnt_q != '0;
    assign do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
    assign valid_o = cnt_q != '0;
    assign data_o = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/fetch_ctrl_multibuf.sv
// fetch_ctrl_multibuf: streams a tile of words from one buffer region of a BRAM
// read port onto a valid/ready stream, with ping-pong banks and credit flow control.
//   start_fetch, reset_addr_counter : start / clear offset+bank (sampled in IDLE)
//   buf_sel, tile_len, double_buffering : fetch configuration, latched on start
//   bram_enb, bram_addrb, bram_doutb : BRAM read port (data RD_LATENCY cycles later)
//   out_data, out_valid, out_ready   : output stream
//   fetch_done, busy, err_cfg, cur_bank : status
module fetch_ctrl_multibuf
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 256,
    parameter int NUM_BUFFERS = NUM_BUFFERS_DEF,
    parameter int BUF_DEPTH   = BUF_DEPTH_DEF,
    parameter int RD_LATENCY  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_fetch,
    input  logic                           reset_addr_counter,
    input  logic [$clog2(NUM_BUFFERS)-1:0] buf_sel,
    input  logic [$clog2(BUF_DEPTH):0]     tile_len,
    input  logic                           double_buffering,
    output logic                           bram_enb,
    output logic [ADDR_WIDTH-1:0]          bram_addrb,
    input  logic [DATA_WIDTH-1:0]          bram_doutb,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           fetch_done,
    output logic                           busy,
    output logic                           err_cfg,
    output logic                           cur_bank
);
    localparam int SW = $clog2(NUM_BUFFERS);
    localparam int OW = $clog2(BUF_DEPTH);
    localparam int TW = OW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    state_e state_q;
    logic [SW-1:0] sel_q;
    logic [TW-1:0] len_q, issued_q, popped_q;
    logic db_q, bank_q, busy_q, done_q, err_q;
    logic [OW-1:0] offset_q, offset_d;
    logic [OW:0] offset_inc;
    logic [RD_LATENCY-1:0] vld_q;
    logic [CW-1:0] fifo_cnt;
    logic cfg_ok, pop, last_issue, last_pop;
    assign cfg_ok = tile_len != '0 && int'(tile_len) <= region_size(BUF_DEPTH, double_buffering);
    // A read is only issued when a FIFO slot is guaranteed for its data.
    assign bram_enb = state_q == ISSUE && ($countones(vld_q) + int'(fifo_cnt) < FIFO_DEPTH);
    assign offset_inc = {1'b0, offset_q} + 1'b1;
    assign offset_d = int'(offset_inc) >= region_size(BUF_DEPTH, db_q) ? '0 : offset_inc[OW-1:0];
    assign last_issue = bram_enb && issued_q == len_q - 1'b1;
    assign pop = out_valid && out_ready;
    assign last_pop = state_q == DRAIN && pop && popped_q == len_q - 1'b1;
    // BUF_DEPTH is a power of two, so region and bank bases are plain concatenations.
    assign bram_addrb = ADDR_WIDTH'({sel_q, {OW{1'b0}}})
                      + ADDR_WIDTH'({db_q & bank_q, {(OW-1){1'b0}}})
                      + ADDR_WIDTH'(offset_q);
    assign fetch_done = done_q;
    assign busy = busy_q;
    assign err_cfg = err_q;
    assign cur_bank = bank_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q <= '0;
            len_q <= '0;
            issued_q <= '0;
            popped_q <= '0;
            db_q <= 1'b0;
            bank_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            offset_q <= '0;
            vld_q <= '0;
        end else begin
            vld_q <= RD_LATENCY'({vld_q, bram_enb});
            done_q <= 1'b0;
            err_q <= 1'b0;
            if (bram_enb) begin
                offset_q <= offset_d;
                issued_q <= issued_q + 1'b1;
            end
            if (pop) popped_q <= popped_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (reset_addr_counter) begin
                        offset_q <= '0;
                        bank_q <= 1'b0;
                    end
                    if (start_fetch && cfg_ok) begin
                        state_q <= ISSUE;
                        sel_q <= buf_sel;
                        len_q <= tile_len;
                        db_q <= double_buffering;
                        busy_q <= 1'b1;
                        issued_q <= '0;
                        popped_q <= '0;
                    end else if (start_fetch) begin
                        err_q <= 1'b1;
                    end
                end
                ISSUE: if (last_issue) state_q <= DRAIN;
                DRAIN: begin
                    if (last_pop) begin
                        state_q <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        if (db_q) begin
                            bank_q <= !bank_q;
                            offset_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    sync_fifo_fwft #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push_i(vld_q[RD_LATENCY-1]),
        .data_i(bram_doutb),
        .pop_i(pop),
        .data_o(out_data),
        .valid_o(out_valid),
        .count_o(fifo_cnt)
    );
endmodule

// File: tb/tb_fetch_ctrl_multibuf.sv
// tb_fetch_ctrl_multibuf: directed self-checking bench for fetch_ctrl_multibuf.
module tb_fetch_ctrl_multibuf;
    import fetch_pkg::*;
    localparam int AW = 16;
    localparam int DW = 256;
    localparam int RL = 2;
    localparam int FD = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_fetch = 1'b0;
    logic reset_addr_counter = 1'b0;
    logic double_buffering = 1'b0;
    logic out_ready = 1'b1;
    logic [BUF_SEL_W-1:0] buf_sel = '0;
    logic [TILE_W-1:0] tile_len = '0;
    logic bram_enb, out_valid, fetch_done, busy, err_cfg, cur_bank;
    logic [AW-1:0] bram_addrb;
    logic [DW-1:0] bram_doutb, out_data;
    logic [AW-1:0] pipe [RL];
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int addr_q[$];
    int data_q[$];
    int first_enb, last_enb, first_pop, last_pop, done_cyc, n_enb, n_pop, occ_max;
    bit busy_at_done;

    always #5 clk = ~clk;

    fetch_ctrl_multibuf #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BUFFERS(NUM_BUFFERS_DEF),
        .BUF_DEPTH(BUF_DEPTH_DEF), .RD_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_fetch(start_fetch),
        .reset_addr_counter(reset_addr_counter), .buf_sel(buf_sel),
        .tile_len(tile_len), .double_buffering(double_buffering),
        .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fetch_done(fetch_done), .busy(busy), .err_cfg(err_cfg), .cur_bank(cur_bank)
    );

    // BRAM model: word content equals its address, RL-cycle read pipeline.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= bram_addrb;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_doutb = DW'(pipe[RL-1]);

    always @(negedge clk) begin
        if (bram_enb) begin
            if (n_enb == 0) first_enb = cyc;
            last_enb = cyc;
            addr_q.push_back(int'(bram_addrb));
            n_enb++;
        end
        if (out_valid && out_ready) begin
            if (n_pop == 0) first_pop = cyc;
            last_pop = cyc;
            data_q.push_back(int'(out_data[31:0]));
            n_pop++;
        end
        if (n_enb - n_pop > occ_max) occ_max = n_enb - n_pop;
        if (fetch_done) done_cyc = cyc;
    end

    task automatic clear_mon();
        addr_q.delete();
        data_q.delete();
        n_enb = 0;
        n_pop = 0;
        occ_max = 0;
        done_cyc = -1;
        first_enb = -1;
        first_pop = -1;
        last_enb = -1;
        last_pop = -1;
    endtask

    function automatic int seq_err(input int base, input int n);
        int e = 0;
        if (addr_q.size() != n) e++;
        if (data_q.size() != n) e++;
        foreach (addr_q[i]) if (addr_q[i] != base + i) e++;
        foreach (data_q[i]) if (data_q[i] != base + i) e++;
        return e;
    endfunction

    // Caller is at posedge+1. Returns at posedge+1 after the fetch_done cycle.
    task automatic run_fetch(input int sel, input int len, input bit db, input bit clr,
                             input bit bp, output int sc, output bit to);
        clear_mon();
        buf_sel = BUF_SEL_W'(sel);
        tile_len = TILE_W'(len);
        double_buffering = db;
        reset_addr_counter = clr;
        start_fetch = 1'b1;
        out_ready = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start_fetch = 1'b0;
        reset_addr_counter = 1'b0;
        buf_sel = ~buf_sel;
        tile_len = '0;
        double_buffering = !db;
        to = 1'b1;
        for (int k = 1; k < 3000; k++) begin
            out_ready = bp ? (k % 3 == 0) : 1'b1;
            @(negedge clk);
            if (fetch_done) begin
                busy_at_done = busy;
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (bram_enb !== 1'b0) begin miscompares++; $display("FAIL rst_enb got=%b exp=0", bram_enb); end
        vectors++; if (bram_addrb !== '0) begin miscompares++; $display("FAIL rst_addr got=%0d exp=0", bram_addrb); end
        vectors++; if ({out_valid, fetch_done, busy, err_cfg, cur_bank} !== 5'b0) begin miscompares++; $display("FAIL rst_status got=%b exp=00000", {out_valid, fetch_done, busy, err_cfg, cur_bank}); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rst_data got=%0h exp=0", out_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int sc; bit to; int e;
        run_fetch(0, 32, 1'b0, 1'b0, 1'b0, sc, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL basic_timeout got=%b exp=0", to); end
        e = seq_err(0, 32);
        vectors++; if (e !== 0) begin miscompares++; $display("FAIL basic_seq errors=%0d exp=0", e); end
        vectors++; if (first_enb - sc !== 1) begin miscompares++; $display("FAIL basic_enb_lat got=%0d exp=1", first_enb - sc); end
        vectors++; if (first_pop - first_enb !== RL + 1) begin miscompares++; $display("FAIL basic_valid_lat got=%0d exp=%0d", first_pop - first_enb, RL + 1); end
        vectors++; if (last_pop - first_pop !== 31) begin miscompares++; $display("FAIL basic_rate got=%0d exp=31", last_pop - first_pop); end
        vectors++; if (done_cyc - last_pop !== 1) begin miscompares++; $display("FAIL basic_done_lat got=%0d exp=1", done_cyc - last_pop); end
        vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done got=%b exp=0", busy_at_done); end
        vectors++; if ({fetch_done, busy} !== 2'b00) begin miscompares++; $display("FAIL basic_after got=%b exp=00", {fetch_done, busy}); end
    endtask

    task automatic test_walk();
        int sc; bit to; int e;
        run_fetch(0, 32, 1'b0, 1'b0, 1'b0, sc, to);
        e = seq_err(32, 32);
        vectors++; if (to !== 1'b0 || e !== 0) begin miscompares++; $display("FAIL walk_second to=%b errors=%0d exp=0/0", to, e); end
        run_fetch(2, 512, 1'b0, 1'b1, 1'b0, sc, to);
        e = seq_err(2048, 512);
        vectors++; if (to !== 1'b0 || e !== 0) begin miscompares++; $display("FAIL walk_region2 to=%b errors=%0d exp=0/0", to, e); end
        vectors++; if (addr_q.size() > 0 && addr_q[$] !== 2559) begin miscompares++; $display("FAIL walk_last_addr got=%0d exp=2559", addr_q[$]); end
    endtask

    task automatic test_double_buffer();
        int sc; bit to; int e;
        int bases[3] = '{0, 512, 0};
        bit banks[3] = '{1'b1, 1'b0, 1'b1};
        for (int f = 0; f < 3; f++) begin
            run_fetch(0, 512, 1'b1, f == 0, 1'b0, sc, to);
            e = seq_err(bases[f], 512);
            vectors++; if (to !== 1'b0 || e !== 0) begin miscompares++; $display("FAIL db_fetch%0d to=%b errors=%0d exp=0/0", f, to, e); end
            vectors++; if (cur_bank !== banks[f]) begin miscompares++; $display("FAIL db_bank%0d got=%b exp=%b", f, cur_bank, banks[f]); end
        end
    endtask

    task automatic test_backpressure();
        int sc; bit to; int e;
        run_fetch(1, 16, 1'b0, 1'b1, 1'b1, sc, to);
        e = seq_err(1024, 16);
        vectors++; if (to !== 1'b0 || e !== 0) begin miscompares++; $display("FAIL bp_seq to=%b errors=%0d exp=0/0", to, e); end
        vectors++; if (occ_max !== FD) begin miscompares++; $display("FAIL bp_credits got=%0d exp=%0d", occ_max, FD); end
        vectors++; if (last_enb - first_enb <= 15) begin miscompares++; $display("FAIL bp_stall span=%0d exp>15", last_enb - first_enb); end
    endtask

    task automatic test_cfg_err();
        int lens[2] = '{0, 600};
        for (int t = 0; t < 2; t++) begin
            clear_mon();
            buf_sel = '0;
            tile_len = TILE_W'(lens[t]);
            double_buffering = t == 1;
            start_fetch = 1'b1;
            @(negedge clk);
            vectors++; if (err_cfg !== 1'b0) begin miscompares++; $display("FAIL err_early%0d got=%b exp=0", t, err_cfg); end
            @(posedge clk); #1;
            start_fetch = 1'b0;
            @(negedge clk);
            vectors++; if (err_cfg !== 1'b1) begin miscompares++; $display("FAIL err_pulse%0d got=%b exp=1", t, err_cfg); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL err_busy%0d got=%b exp=0", t, busy); end
            @(negedge clk);
            vectors++; if (err_cfg !== 1'b0) begin miscompares++; $display("FAIL err_width%0d got=%b exp=0", t, err_cfg); end
            repeat (3) @(negedge clk);
            @(posedge clk); #1;
            vectors++; if (n_enb !== 0) begin miscompares++; $display("FAIL err_noread%0d got=%0d exp=0", t, n_enb); end
        end
    endtask

    task automatic test_reset_mid();
        int sc; bit to; int e;
        clear_mon();
        buf_sel = '0;
        tile_len = TILE_W'(32);
        double_buffering = 1'b0;
        reset_addr_counter = 1'b1;
        start_fetch = 1'b1;
        @(posedge clk); #1;
        start_fetch = 1'b0;
        reset_addr_counter = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (n_pop >= 6) begin
                to = 1'b0;
                break;
            end
        end
        vectors++; if (to !== 1'b0 || n_pop !== 6 || busy !== 1'b1) begin miscompares++; $display("FAIL mid_prefix to=%b pops=%0d busy=%b exp=0/6/1", to, n_pop, busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({bram_enb, out_valid, fetch_done, busy, err_cfg, cur_bank} !== 6'b0) begin miscompares++; $display("FAIL mid_rst_status got=%b exp=000000", {bram_enb, out_valid, fetch_done, busy, err_cfg, cur_bank}); end
        vectors++; if (bram_addrb !== '0 || out_data !== '0) begin miscompares++; $display("FAIL mid_rst_bus addr=%0d data=%0h exp=0/0", bram_addrb, out_data); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (n_enb !== 0 || n_pop !== 0) begin miscompares++; $display("FAIL mid_quiet enb=%0d pops=%0d exp=0/0", n_enb, n_pop); end
        run_fetch(0, 8, 1'b0, 1'b0, 1'b0, sc, to);
        e = seq_err(0, 8);
        vectors++; if (to !== 1'b0 || e !== 0) begin miscompares++; $display("FAIL mid_refetch to=%b errors=%0d exp=0/0", to, e); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_walk();
        test_double_buffer();
        test_backpressure();
        test_cfg_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
